// File: rtl/codec_pkg.sv
// Shared types and constants for the serial codec interface.
// Frame geometry, state encoding and frame-position constants.
package codec_pkg;

  localparam int SMPL_W  = 16;
  localparam int CNT_W   = 10;
  localparam int SCLK_LG = 5;
  localparam int FRM_W   = 2 * SMPL_W;

  typedef logic [FRM_W-1:0]  frame_t;
  typedef logic [SMPL_W-1:0] smpl_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    INIT,
    SYNC,
    RUN
  } codec_state_t;

  // Last count of the frame: TX load and FSM step.
  localparam cnt_t TX_LOAD = '1;

  // Last SCLK rise of the frame: half an SCLK before TX_LOAD.
  localparam cnt_t RX_LAST_RISE =
    TX_LOAD & ~cnt_t'(1 << (SCLK_LG - 1));

  // Phase within one SCLK period of the rise/fall events.
  localparam logic [SCLK_LG-1:0] RISE_PH =
    {1'b0, {(SCLK_LG-1){1'b1}}};
  localparam logic [SCLK_LG-1:0] FALL_PH = '1;

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter and derived codec clocks.
// Clocks are raw counter bits so they never glitch.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_mclk,
  output logic             o_sclk,
  output logic             o_lrclk,
  output logic             o_rise_ev,
  output logic             o_fall_ev,
  output logic             o_frame_end
);

  cnt_t r_cnt;

  // Counter wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_mclk  = r_cnt[1];
  assign o_sclk  = r_cnt[SCLK_LG-1];
  assign o_lrclk = r_cnt[CNT_W-1];

  // Events fire on the clk edge that moves SCLK.
  assign o_rise_ev =
    (r_cnt[SCLK_LG-1:0] == RISE_PH);
  assign o_fall_ev =
    (r_cnt[SCLK_LG-1:0] == FALL_PH);
  assign o_frame_end = (r_cnt == TX_LOAD);

endmodule

// File: rtl/codec_intf.sv
// Codec pin interface: clocks, ADC deserialiser, DAC serialiser.
// Option CODEC_LOOPBACK_EN adds an ADC->DAC bypass input.
module codec_intf
  import codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rht_in,
  input  logic              ADC_SDout,
`ifdef CODEC_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [SMPL_W-1:0] lft_out,
  output logic [SMPL_W-1:0] rht_out,
  output logic              valid,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              RSTn,
  output logic              DAC_SDin
);

  cnt_t         w_cnt;
  logic         w_rise_ev;
  logic         w_fall_ev;
  logic         w_frame_end;

  codec_state_t r_state;
  codec_state_t w_state_nxt;
  logic         w_rstn_nxt;
  logic         w_cap_en;
  logic         w_valid_nxt;

  frame_t       r_rx;
  frame_t       w_rx_nxt;
  smpl_t        r_lft;
  smpl_t        r_rht;
  logic         r_valid;
  logic         r_rstn;

  frame_t       r_tx;
  frame_t       w_tx_src;
  logic         r_dac;

  codec_clk_gen u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_cnt       (w_cnt),
    .o_mclk      (MCLK),
    .o_sclk      (SCLK),
    .o_lrclk     (LRCLK),
    .o_rise_ev   (w_rise_ev),
    .o_fall_ev   (w_fall_ev),
    .o_frame_end (w_frame_end)
  );

  // State register: INIT holds codec in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_rstn  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rstn  <= w_rstn_nxt;
    end
  end

  // Next state only at frame boundary; capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_end) begin
      case (r_state)
        INIT:    w_state_nxt = SYNC;
        SYNC:    w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = INIT;
      endcase
    end
    w_rstn_nxt  = (w_state_nxt != INIT);
    w_cap_en    = w_rise_ev &&
                  (w_cnt == RX_LAST_RISE);
    w_valid_nxt = w_cap_en && (r_state == RUN);
  end

  assign w_rx_nxt =
    {r_rx[FRM_W-2:0], ADC_SDout};

  // ADC shift register samples on each SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx <= '0;
    end else if (w_rise_ev) begin
      r_rx <= w_rx_nxt;
    end
  end

  // Output pair includes the bit taken on the last rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft   <= '0;
      r_rht   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_lft <= w_rx_nxt[FRM_W-1:SMPL_W];
        r_rht <= w_rx_nxt[SMPL_W-1:0];
      end
    end
  end

`ifdef CODEC_LOOPBACK_EN
  assign w_tx_src = loopback ?
    {r_lft, r_rht} : {lft_in, rht_in};
`else
  assign w_tx_src = {lft_in, rht_in};
`endif

  // DAC shifter: load at frame end beats fall shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx  <= '0;
      r_dac <= 1'b0;
    end else if (w_frame_end) begin
      r_tx  <= w_tx_src;
      r_dac <= w_tx_src[FRM_W-1];
    end else if (w_fall_ev) begin
      r_tx  <= {r_tx[FRM_W-2:0], 1'b0};
      r_dac <= r_tx[FRM_W-2];
    end
  end

  assign lft_out  = r_lft;
  assign rht_out  = r_rht;
  assign valid    = r_valid;
  assign RSTn     = r_rstn;
  assign DAC_SDin = r_dac;

endmodule

// File: tb/tb_codec_intf.sv
// Scoreboard bench for codec_intf: random frames vs frame-level model.
// Build with CODEC_LOOPBACK_EN to also exercise the bypass.
module tb_codec_intf;
  import codec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lft_in, rht_in;
  logic        ADC_SDout;
  logic        lb;
  logic [15:0] lft_out, rht_out;
  logic        valid, MCLK, SCLK, LRCLK, RSTn, DAC_SDin;

  always #5 clk = ~clk;

  codec_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_in    (lft_in),
    .rht_in    (rht_in),
    .ADC_SDout (ADC_SDout),
`ifdef CODEC_LOOPBACK_EN
    .loopback  (lb),
`endif
    .lft_out   (lft_out),
    .rht_out   (rht_out),
    .valid     (valid),
    .MCLK      (MCLK),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .RSTn      (RSTn),
    .DAC_SDin  (DAC_SDin)
  );

  typedef struct {
    logic [31:0] data;
    int          at;
  } rx_exp_t;

  rx_exp_t     rxq[$];
  logic [31:0] dacq[$];
  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [31:0] adc_cur;
  logic [31:0] model_out;

  // Clocks elapsed since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else k <= k + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (k=%0d)",
               nm, act, exp, k);
    end
  endtask

  // Codec model + expectation producer for one clk.
  task automatic drive_cycle();
    int c;
    int f;
    rx_exp_t e;
    c = k % 1024;
    f = k / 1024;
    if (c == 0) begin
      adc_cur = (f < 4) ? 32'hA5C33C5A : $urandom;
      if (f >= 2) begin
        e.data = adc_cur;
        e.at   = f * 1024 + 'h3F0;
        rxq.push_back(e);
      end
    end
    ADC_SDout = adc_cur[31 - c / 32];
    if (c == 'h200 && f >= 1) begin
      lft_in = 16'($urandom);
      rht_in = 16'($urandom);
    end
`ifdef CODEC_LOOPBACK_EN
    if (c == 'h300) lb = (f >= 2) ? 1'($urandom) : 1'b0;
`endif
    if (c == 'h3FF) begin
      if (f >= 2) model_out = adc_cur;
      dacq.push_back(lb ? model_out : {lft_in, rht_in});
    end
  endtask

  task automatic run_until(input int kend);
    int budget;
    budget = 20000;
    while (k != kend && budget > 0) begin
      @(negedge clk);
      drive_cycle();
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL run_until: k=%0d never reached %0d",
               k, kend);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lft"}, 32'(lft_out), 0);
    chk({tag, "_rht"}, 32'(rht_out), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_dac"}, 32'(DAC_SDin), 0);
    chk({tag, "_rstn"}, 32'(RSTn), 0);
    chk({tag, "_mclk"}, 32'(MCLK), 0);
    chk({tag, "_sclk"}, 32'(SCLK), 0);
    chk({tag, "_lrclk"}, 32'(LRCLK), 0);
  endtask

  logic        prev_sclk = 1'b0;
  int          nbits = 0;
  logic [31:0] dac_acc = '0;

  // Monitor: pops expectations when the DUT presents data.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk = 1'b0;
      nbits = 0;
    end else begin
      if (k < 1024) begin
        chk("mclk", 32'(MCLK), 32'((k >> 1) & 1));
        chk("sclk", 32'(SCLK), 32'((k >> 4) & 1));
        chk("lrclk", 32'(LRCLK), 32'((k >> 9) & 1));
      end
      if (k < 3072 && k % 128 == 0)
        chk("rstn", 32'(RSTn), 32'(k >= 1024));
      if (valid) begin
        if (rxq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: valid at k=%0d want none",
                   k);
        end else begin
          rx_exp_t e;
          e = rxq.pop_front();
          chk("rx_time", k, e.at);
          chk("rx_lft", 32'(lft_out), 32'(e.data[31:16]));
          chk("rx_rht", 32'(rht_out), 32'(e.data[15:0]));
        end
      end
      if (SCLK && !prev_sclk) begin
        chk("sclk_phase", k % 32, 16);
        dac_acc = {dac_acc[30:0], DAC_SDin};
        nbits++;
        if (nbits == 32) begin
          nbits = 0;
          chk("dac_time", k % 1024, 'h3F0);
          if (dacq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dac_unexpected: got %h want none",
                     dac_acc);
          end else begin
            chk("dac_frame", dac_acc, dacq.pop_front());
          end
        end
      end
      prev_sclk = SCLK;
    end
  end

  initial begin
    lft_in    = 16'h8001;
    rht_in    = 16'h7FFE;
    ADC_SDout = 1'b0;
    lb        = 1'b0;
    model_out = '0;
    adc_cur   = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    dacq.push_back('0);
    rst_n = 1'b1;
    drive_cycle();
    run_until(3 * 1024 + 'h1A3);

    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    rxq.delete();
    dacq.delete();
    model_out = '0;
    lb        = 1'b0;
    lft_in    = 16'h8001;
    rht_in    = 16'h7FFE;
    repeat (4) @(negedge clk);
    chk_all_zero("held");
    dacq.push_back('0);
    rst_n = 1'b1;
    drive_cycle();
    run_until(5 * 1024 + 'h3F8);

    chk("rxq_drained", 32'(rxq.size()), 0);
    chk("dacq_drained", 32'(dacq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
